// File: rtl/gpio_wb_pkg.sv
// Shared types, window codes and helpers for the gpioCtrl Wishbone bridge.
package gpio_wb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCtrl,
        StRamReq,
        StRamRd,
        StRamWr,
        StAck
    } state_e;

    localparam logic [1:0]  WIN_CTRL    = 2'b00;
    localparam logic [1:0]  WIN_RAM     = 2'b01;
    localparam int unsigned RAM_WORDS   = 64;
    localparam int unsigned TIMEOUT_DEF = 4095;

    // Per byte lane: take new_data where sel is set, otherwise keep old_data.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  sel,
                                                input logic [31:0] new_data,
                                                input logic [31:0] old_data);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_wb_bridge_arb.sv
// Combinational RAM port arbiter: gpioCtrl always wins, host is granted only when gpio is idle.
module gpio_ram_arb (
    input  logic        i_gpio_csb,
    input  logic        i_gpio_web,
    input  logic [7:0]  i_gpio_addr,
    input  logic [31:0] i_gpio_wdata,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [7:0]  i_host_addr,
    input  logic [31:0] i_host_wdata,
    output logic        o_host_gnt,
    output logic        o_ram_csb,
    output logic        o_ram_web,
    output logic [7:0]  o_ram_addr,
    output logic [31:0] o_ram_wdata
);

    always_comb begin
        o_ram_csb   = i_gpio_csb;
        o_ram_web   = i_gpio_web;
        o_ram_addr  = i_gpio_addr;
        o_ram_wdata = i_gpio_wdata;
        o_host_gnt  = 1'b0;
        if (i_gpio_csb && i_host_req) begin
            o_ram_csb   = 1'b0;
            o_ram_web   = ~i_host_we;
            o_ram_addr  = i_host_addr;
            o_ram_wdata = i_host_wdata;
            o_host_gnt  = 1'b1;
        end else if (i_gpio_csb) begin
            o_ram_web = 1'b1;
        end
    end

endmodule

// File: rtl/gpio_wb_bridge.sv
// Wishbone classic slave giving the management core access to gpioCtrl's
// control registers and its shared pattern RAM.
module gpio_wb_bridge
    import gpio_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        ctrl_we_o,
    output logic [3:0]  ctrl_addr_o,
    output logic [31:0] ctrl_wdata_o,
    input  logic [31:0] ctrl_rdata_i,
    input  logic        gpio_ram_csb_i,
    input  logic        gpio_ram_web_i,
    input  logic [7:0]  gpio_ram_addr_i,
    input  logic [31:0] gpio_ram_wdata_i,
    output logic [31:0] gpio_ram_rdata_o,
    output logic        ram_csb_o,
    output logic        ram_web_o,
    output logic [7:0]  ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    state_e      r_state, w_state_d;
    logic [11:0] r_tmo, w_tmo_d;
    logic [31:0] r_dat, w_dat_d;
    logic        r_we, w_we_d;
    logic [3:0]  r_sel, w_sel_d;
    logic [31:0] r_wdata, w_wdata_d;
    logic [3:0]  r_ctrl_addr, w_ctrl_addr_d;
    logic [5:0]  r_ram_word, w_ram_word_d;
    logic [31:0] r_merged, w_merged_d;

    logic        w_hit;
    logic [1:0]  w_win;
    logic        w_ram_ok;
    logic [12:0] w_tmo_inc;
    logic        w_tmo_hit;
    logic        w_host_req;
    logic        w_host_we;
    logic        w_host_gnt;
    logic        w_unused;

    assign w_hit     = wb_cyc_i && wb_stb_i && (wb_adr_i[31:12] == BASE_ADR[31:12]);
    assign w_win     = wb_adr_i[11:10];
    assign w_ram_ok  = 32'(wb_adr_i[9:2]) < RAM_WORDS;
    assign w_tmo_inc = {1'b0, r_tmo} + 13'd1;
    assign w_tmo_hit = w_tmo_inc == 13'(TIMEOUT);
    assign w_unused  = ^wb_adr_i[1:0];

    // Host request derives from registered state only, so the grant cannot loop back into it.
    assign w_host_req = (r_state == StRamReq) || (r_state == StRamWr);
    assign w_host_we  = (r_state == StRamWr);

    gpio_ram_arb u_arb (
        .i_gpio_csb   (gpio_ram_csb_i),
        .i_gpio_web   (gpio_ram_web_i),
        .i_gpio_addr  (gpio_ram_addr_i),
        .i_gpio_wdata (gpio_ram_wdata_i),
        .i_host_req   (w_host_req),
        .i_host_we    (w_host_we),
        .i_host_addr  ({r_ram_word, 2'b00}),
        .i_host_wdata (r_merged),
        .o_host_gnt   (w_host_gnt),
        .o_ram_csb    (ram_csb_o),
        .o_ram_web    (ram_web_o),
        .o_ram_addr   (ram_addr_o),
        .o_ram_wdata  (ram_wdata_o)
    );

    always_comb begin
        w_state_d     = r_state;
        w_tmo_d       = r_tmo;
        w_dat_d       = r_dat;
        w_we_d        = r_we;
        w_sel_d       = r_sel;
        w_wdata_d     = r_wdata;
        w_ctrl_addr_d = r_ctrl_addr;
        w_ram_word_d  = r_ram_word;
        w_merged_d    = r_merged;
        unique case (r_state)
            StIdle: begin
                if (w_hit) begin
                    w_we_d    = wb_we_i;
                    w_sel_d   = wb_sel_i;
                    w_wdata_d = wb_dat_i;
                    w_dat_d   = '0;
                    if (w_win == WIN_CTRL) begin
                        w_ctrl_addr_d = {wb_adr_i[3:2], 2'b00};
                        w_state_d     = StCtrl;
                    end else if (w_win == WIN_RAM && w_ram_ok) begin
                        w_ram_word_d = wb_adr_i[7:2];
                        w_state_d    = StRamReq;
                    end else begin
                        w_state_d = StAck;
                    end
                end
            end
            StCtrl: begin
                if (!r_we) w_dat_d = ctrl_rdata_i;
                w_state_d = StAck;
            end
            StRamReq: begin
                if (w_host_gnt) begin
                    w_state_d = StRamRd;
                end else if (w_tmo_hit) begin
                    w_dat_d   = '1;
                    w_state_d = StAck;
                end else begin
                    w_tmo_d = w_tmo_inc[11:0];
                end
            end
            StRamRd: begin
                w_merged_d = merge_bytes(r_sel, r_wdata, ram_rdata_i);
                if (r_we) begin
                    w_state_d = StRamWr;
                end else begin
                    w_dat_d   = ram_rdata_i;
                    w_state_d = StAck;
                end
            end
            StRamWr: begin
                if (w_host_gnt) begin
                    w_state_d = StAck;
                end else if (w_tmo_hit) begin
                    w_dat_d   = '1;
                    w_state_d = StAck;
                end else begin
                    w_tmo_d = w_tmo_inc[11:0];
                end
            end
            StAck:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_state_d != r_state) w_tmo_d = '0;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state     <= StIdle;
            r_tmo       <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_wdata     <= '0;
            r_ctrl_addr <= '0;
            r_ram_word  <= '0;
            r_merged    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_tmo       <= w_tmo_d;
            r_dat       <= w_dat_d;
            r_we        <= w_we_d;
            r_sel       <= w_sel_d;
            r_wdata     <= w_wdata_d;
            r_ctrl_addr <= w_ctrl_addr_d;
            r_ram_word  <= w_ram_word_d;
            r_merged    <= w_merged_d;
        end
    end

    assign wb_ack_o         = (r_state == StAck);
    assign wb_dat_o         = r_dat;
    assign ctrl_we_o        = (r_state == StCtrl) && r_we;
    assign ctrl_addr_o      = r_ctrl_addr;
    assign ctrl_wdata_o     = ctrl_we_o ? merge_bytes(r_sel, r_wdata, ctrl_rdata_i) : '0;
    assign gpio_ram_rdata_o = ram_rdata_i;

endmodule

// File: doc/gpio_wb_bridge.md
Name: gpio_wb_bridge

Overview:
- Wishbone classic slave that gives the Caravel management core access to gpioCtrl.
- Initiator side of gpioCtrl's control interface: drives CTRL_WE/CTRL_ADDR/CTRL_DATA_IN, reads CTRL_DATA_OUT.
- Shares gpioCtrl's pattern RAM with the host. gpioCtrl always has RAM priority; host accesses stall until the RAM is free.
- Byte-enable writes that gpioCtrl/RAM cannot take natively are handled by read-modify-write.

Parameters:
BASE_ADR, 32'h3000_0000, slave base; decode on wb_adr_i[31:12]==BASE_ADR[31:12]
TIMEOUT, 4095, max cycles a host RAM access waits for grant (12-bit counter)

Ports:
CLK  in  1  clock
RSTb  in  1  reset, asynchronous, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write
wb_sel_i  in  4  byte enables
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_ack_o  out  1  acknowledge, one-cycle pulse
wb_dat_o  out  32  read data, valid with ack
ctrl_we_o  out  1  to gpioCtrl CTRL_WE
ctrl_addr_o  out  4  to gpioCtrl CTRL_ADDR
ctrl_wdata_o  out  32  to gpioCtrl CTRL_DATA_IN
ctrl_rdata_i  in  32  from gpioCtrl CTRL_DATA_OUT (combinational on addr)
gpio_ram_csb_i  in  1  gpioCtrl RAM chip select, active-low
gpio_ram_web_i  in  1  gpioCtrl RAM write enable, active-low
gpio_ram_addr_i  in  8  gpioCtrl RAM byte address
gpio_ram_wdata_i  in  32  gpioCtrl RAM write data
gpio_ram_rdata_o  out  32  to gpioCtrl = ram_rdata_i, always passed through
ram_csb_o / ram_web_o  out  1/1  RAM macro controls, active-low
ram_addr_o  out  8  RAM byte address, [1:0]=00
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data; synchronous, valid the cycle after the access

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, ctrl_we_o=0, ctrl_addr_o=0, ctrl_wdata_o=0, FSM=IDLE, timeout count=0. Host RAM request is idle, so the RAM ports mirror the gpio side. Reset mid-transaction aborts it with no ack.
- Decode, on a hit (cyc&stb and base match):
  - wb_adr_i[11:10]=00: CTRL window; ctrl_addr_o={adr[3:2],2'b00}.
  - 01: RAM window, 64 words; ram_addr_o={adr[7:2],2'b00}; adr[9:8]!=0 is unmapped.
  - 10/11: unmapped.
- Non-hit: ignored, no ack.
- RAM arbiter (combinational): if gpio_ram_csb_i==0, RAM ports = gpio signals and there is no host grant. Otherwise RAM ports = host request when active, else csb=1, web=1.
- FSM states IDLE, CTRL, RAM_REQ, RAM_RD, RAM_WR, ACK. Transitions from IDLE on a hit:
  - CTRL window -> CTRL.
  - RAM window -> RAM_REQ.
  - Unmapped -> ACK with wb_dat_o=0; writes dropped.
- CTRL: single cycle.
  - Read: capture ctrl_rdata_i into wb_dat_o.
  - Write: ctrl_we_o=1 this cycle only. ctrl_wdata_o = per byte, sel ? wb_dat_i : ctrl_rdata_i (same-cycle merge).
  - Next state ACK. Read latency: stb seen at cycle N, ack at N+2.
- RAM_REQ: host drives csb=0, web=1, so every RAM access starts with a read.
  - On grant -> RAM_RD.
  - If no grant, wait and count. When the count reaches TIMEOUT -> ACK with wb_dat_o=32'hFFFF_FFFF and the write dropped.
- RAM_RD: capture ram_rdata_i.
  - Read, or write with sel=4'hF -> ACK on a read; -> RAM_WR on a write.
  - Partial write -> RAM_WR with merged data held in a register.
  - Uncontended read latency: stb at N, ack at N+3.
- RAM_WR: host drives csb=0, web=0 with the merged word.
  - On grant -> ACK.
  - Waits and times out as in RAM_REQ; on timeout the write is dropped.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. A new request is accepted only in IDLE, so stb still high after ack starts a new transaction.
- Timeout counter clears on every state entry.
- A gpioCtrl request in the same cycle as a host request always wins, with no glitch on the gpio path.

Decomposition:
- Package gpio_wb_pkg:
  - FSM state encodings.
  - Window codes (WIN_CTRL=2'b00, WIN_RAM=2'b01).
  - RAM_WORDS=64, TIMEOUT default.
  - Byte-merge function.
- One sub-module, gpio_ram_arb: combinational priority mux plus host grant output.

Test Plan:
- Write 0x0000_0041 to BASE+0x000, sel=F -> ctrl_we_o pulses 1 cycle with addr 0, data 0x41; ack 2 cycles after stb.
- Read BASE+0x004 with ctrl_rdata_i=0xA5A5_0000 for addr 4 -> wb_dat_o=0xA5A5_0000 with ack.
- Write 0x1122_3344 to BASE+0x408, then read back, gpio idle -> RAM word 2 = 0x1122_3344; read ack at N+3.
- RAM 0x408=0x1122_3344, write 0x0000_AB00 with sel=4'b0010 -> read-modify-write gives 0x1122_AB44.
- Hold gpio_ram_csb_i=0 for 100 cycles while the host reads -> gpio RAM accesses undisturbed; host ack about 2 cycles after release with correct data.
- Hold gpio_ram_csb_i=0 permanently -> ack after 4095 wait cycles with 0xFFFF_FFFF. Pulse RSTb mid-wait -> no ack, FSM back to IDLE.
